// File: rtl/mac_tx_framer.sv
`timescale 1ns/1ps
// GMII transmit framer: preamble/SFD, Ethernet header, payload from an
// upstream byte RAM, zero padding to the minimum payload, CRC-32 FCS and
// an inter-frame gap before the next request is taken.
module mac_tx_framer #(
    parameter int MAX_PAYLOAD = 1500,
    parameter int MIN_PAYLOAD = 46,
    parameter int IFG_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] local_mac_addr,
    input  logic [47:0] dst_mac_addr,
    input  logic [15:0] eth_type,
    input  logic [10:0] payload_len,
    input  logic        tx_req,
    output logic        tx_ack,
    output logic        payload_rd_en,
    output logic [10:0] payload_rd_addr,
    input  logic [7:0]  payload_rdata,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        tx_busy,
    output logic        tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    // state_q/cnt_q describe the byte currently on gmii_txd
    state_t          state_q, state_d;
    logic [10:0]     cnt_q, cnt_d;
    logic [10:0]     len_q, len_d;
    logic [10:0]     rd_cnt_q, rd_cnt_d;
    logic [13:0][7:0] hdr_q, hdr_d;
    logic [31:0]     crc_q, crc_d;
    logic [7:0]      txd_q, txd_d;
    logic            tx_en_q, tx_en_d;
    logic            ack_q, ack_d;
    logic            done_q, done_d;
    logic            rd_en_q, rd_en_d;
    logic [10:0]     rd_addr_q, rd_addr_d;
    logic            needs_pad;
    logic [10:0]     pad_last;
    logic [31:0]     crc_inv;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
            else                c = c >> 1;
        end
        return c;
    endfunction

    assign needs_pad = (len_q < 11'(MIN_PAYLOAD));
    assign pad_last  = 11'(MIN_PAYLOAD) - len_q - 11'd1;
    assign crc_inv   = ~crc_q;

    // Next-state, next output byte, CRC fold and payload read scheduling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        hdr_d     = hdr_q;
        crc_d     = crc_q;
        rd_cnt_d  = rd_cnt_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        txd_d     = '0;
        tx_en_d   = 1'b0;
        ack_d     = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (tx_req) begin
                    state_d  = S_PREAMBLE;
                    cnt_d    = '0;
                    ack_d    = 1'b1;
                    len_d    = (payload_len > 11'(MAX_PAYLOAD)) ? 11'(MAX_PAYLOAD) : payload_len;
                    hdr_d    = {dst_mac_addr, local_mac_addr, eth_type};
                    crc_d    = '1;
                    rd_cnt_d = '0;
                end
            end
            S_PREAMBLE: begin
                if (cnt_q == 11'd7) begin
                    state_d = S_HEADER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_HEADER: begin
                if (cnt_q == 11'd13) begin
                    cnt_d = '0;
                    if (len_q != 11'd0) state_d = S_PAYLOAD;
                    else                state_d = S_PAD;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_PAYLOAD: begin
                if (cnt_q == len_q - 11'd1) begin
                    cnt_d   = '0;
                    state_d = needs_pad ? S_PAD : S_FCS;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_PAD: begin
                if (cnt_q == pad_last) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_FCS: begin
                if (cnt_q == 11'd3) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_IFG: begin
                if (cnt_q == 11'(IFG_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Byte that will be on the wire next cycle
        unique case (state_d)
            S_PREAMBLE: txd_d = (cnt_d == 11'd7) ? 8'hD5 : 8'h55;
            S_HEADER:   txd_d = hdr_q[4'd13 - cnt_d[3:0]];
            S_PAYLOAD:  txd_d = payload_rdata;
            S_FCS: begin
                unique case (cnt_d[1:0])
                    2'd0:    txd_d = crc_inv[7:0];
                    2'd1:    txd_d = crc_inv[15:8];
                    2'd2:    txd_d = crc_inv[23:16];
                    default: txd_d = crc_inv[31:24];
                endcase
            end
            default:    txd_d = '0;
        endcase

        tx_en_d = (state_d inside {S_PREAMBLE, S_HEADER, S_PAYLOAD, S_PAD, S_FCS});

        // CRC folds each covered byte in the same edge it is registered onto the wire
        if (state_d inside {S_HEADER, S_PAYLOAD, S_PAD}) begin
            crc_d = crc32_byte(crc_q, txd_d);
        end

        // Read k is issued three bytes ahead of its wire slot (registered addr,
        // one-cycle RAM, registered txd), so the first read starts at header byte 11
        if ((rd_cnt_q < len_q) &&
            (((state_q == S_HEADER) && (cnt_q >= 11'd11)) || (state_q == S_PAYLOAD))) begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_cnt_q;
            rd_cnt_d  = rd_cnt_q + 11'd1;
        end
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            hdr_q     <= '0;
            crc_q     <= '1;
            txd_q     <= '0;
            tx_en_q   <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            hdr_q     <= hdr_d;
            crc_q     <= crc_d;
            txd_q     <= txd_d;
            tx_en_q   <= tx_en_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign gmii_txd        = txd_q;
    assign gmii_tx_en      = tx_en_q;
    assign tx_ack          = ack_q;
    assign tx_done         = done_q;
    assign payload_rd_en   = rd_en_q;
    assign payload_rd_addr = rd_addr_q;
    assign tx_busy         = (state_q != S_IDLE);

endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
Ethernet MAC transmit framer for the GMII-side TX path. It is the counterpart of the MAC RX path.
- Accepts a frame request from the upper layer (IP/UDP/ARP TX mux) carrying destination MAC, EtherType and payload length.
- Reads the payload from the upper layer's byte RAM.
- Emits a complete frame on gmii_txd/gmii_tx_en: preamble, SFD, header, payload, zero padding, FCS.
- Enforces the inter-frame gap before accepting the next request.

Parameters:
MAX_PAYLOAD, 1500, payload length clamp in bytes.
MIN_PAYLOAD, 46, payload bytes below which zero padding is appended.
IFG_CYCLES, 12, cycles spent in IFG state after the last FCS byte.

Ports:
clk  input  1  GMII TX clock (125 MHz); all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
local_mac_addr  input  48  source MAC; sampled on request acceptance.
dst_mac_addr  input  48  destination MAC; sampled on acceptance.
eth_type  input  16  EtherType (0x0800 IP, 0x0806 ARP); sampled on acceptance.
payload_len  input  11  payload bytes; sampled on acceptance.
tx_req  input  1  level request; held by upstream until tx_ack.
tx_ack  output  1  one-cycle pulse: request accepted, inputs latched.
payload_rd_en  output  1  payload RAM read enable.
payload_rd_addr  output  11  payload RAM byte address, 0-based.
payload_rdata  input  8  payload RAM data, valid one cycle after rd_en/addr.
gmii_tx_en  output  1  frame byte valid.
gmii_txd  output  8  frame byte.
tx_busy  output  1  high in every state except IDLE.
tx_done  output  1  one-cycle pulse on the cycle after the last FCS byte.

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; counters 0; CRC register 0xFFFFFFFF. A frame in progress is truncated: tx_en falls immediately, with no FCS.
- Outputs gmii_txd, gmii_tx_en, tx_ack, tx_done, payload_rd_en and payload_rd_addr are all registered.
- States: IDLE -> PREAMBLE -> HEADER -> PAYLOAD -> PAD -> FCS -> IFG -> IDLE.
- IDLE:
  - tx_req sampled high at cycle N -> at N+1: tx_ack=1, tx_busy=1, gmii_tx_en=1, gmii_txd=0x55.
  - Latched length L = min(payload_len, MAX_PAYLOAD).
- PREAMBLE: 7 bytes of 0x55, then 1 byte 0xD5 (SFD).
- HEADER: 14 bytes: dst_mac MSB byte first, then local_mac MSB byte first, then eth_type high byte, then low byte.
- PAYLOAD:
  - L bytes. Byte k appears on gmii_txd exactly 2 cycles after the cycle where payload_rd_en=1 and payload_rd_addr=k.
  - Reads are issued early so that payload follows the last header byte with no gap.
  - Addresses run 0..L-1 contiguously; rd_en is never high outside this window.
  - L=0 skips PAYLOAD and issues no reads.
- PAD: if L<MIN_PAYLOAD, send MIN_PAYLOAD-L bytes of 0x00; otherwise skip.
- FCS:
  - CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Covers every byte from the first header byte through the last pad byte; preamble and SFD are excluded.
  - Transmitted value is the inverted register, sent bits[7:0] first, then [15:8], [23:16], [31:24].
  - The CRC is computed on the byte stream as driven, so there is no extra latency.
- IFG: gmii_tx_en=0 and gmii_txd=0x00 for IFG_CYCLES cycles; tx_done pulses on the first IFG cycle; then return to IDLE.
- Minimum tx_en-low gap between back-to-back frames is IFG_CYCLES+1 cycles (IFG state plus one IDLE sampling cycle).
- Frame length on the wire (tx_en high cycles) = 8 + 14 + max(L, MIN_PAYLOAD) + 4.
- tx_req while busy: ignored, with no ack. Upstream holds it, and it is accepted in the next IDLE.
- Input changes after tx_ack have no effect on the current frame.

Test Plan:
- Reset, then tx_req with L=100, dst=FF:FF:FF:FF:FF:FF, src=00:0A:35:01:FE:C0, type=0x0800 -> tx_ack at N+1; tx_en high for 126 cycles; bytes are 55×7, D5, FF×6, 00 0A 35 01 FE C0, 08 00, then RAM bytes 0..99, then FCS. tx_done pulses one cycle after the last FCS byte.
- L=18 -> 72 tx_en cycles; 28 bytes of 0x00 between payload byte 17 and the FCS; payload_rd_addr runs 0..17 only.
- L=0 -> no payload_rd_en at any time; 46 pad bytes; 72 tx_en cycles.
- FCS check: bench CRC-32 model run over header through FCS ends with register value 0xDEBB20E3 (pre-inversion residue) for random L in 0..1500. A payload_len of 2000 is clamped: 1526 tx_en cycles.
- tx_req held high continuously for two frames -> exactly 13 tx_en-low cycles between frames; tx_req toggled mid-frame -> no extra tx_ack.
- rst_n asserted mid-PAYLOAD -> gmii_tx_en=0 and tx_busy=0 immediately (asynchronously). After release, a new request produces a correct full frame.
